rom_access_arbiter: RTL
=======================

// Module: rom_access_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single-port rom_C and rom_read_and_D between N_REQ
//  pipeline stages (get_data_* / Occ fetch stages). One request is accepted per cycle.
//  The block drives the ROM enables and addresses from registers, tracks in-flight reads
//  through a ROM_LAT-deep tag pipeline, and returns d_i, read_i and C tagged with the
//  requester id. Full throughput is one read per cycle.
// PARAMETERS
//  N_REQ    2  number of requesters (2..8)
//  ID_W     3  width of rsp_id; must satisfy 2**ID_W >= N_REQ
//  ROM_LAT  1  synchronous ROM read latency, in cycles from ce/addr registered to data valid
// PORTS
//  clk                 in   1          rising-edge clock
//  rst_n               in   1          asynchronous active-low reset
//  flush               in   1          synchronous; drops in-flight reads, blocks grants
//  req                 in   N_REQ      request per requester; held until gnt
//  req_use_C           in   N_REQ      request reads rom_C
//  req_use_D           in   N_REQ      request reads rom_read_and_D
//  req_addr_C          in   2*N_REQ    rom_C address (base letter A/C/G/T = 0..3); slice r
//  req_addr_D          in   8*N_REQ    rom_read_and_D address (i); slice r
//  gnt                 out  N_REQ      one-hot grant, combinational, same cycle as accept
//  ce_rom_C            out  1          rom_C enable (registered)
//  ce_rom_read_and_D   out  1          rom_read_and_D enable (registered)
//  addr_rom_C          out  2          rom_C address (registered)
//  addr_rom_read_and_D out  8          rom_read_and_D address (registered)
//  data                in   8          rom_C read data
//  d_i                 in   8          rom_read_and_D D[i] data
//  read_i              in   2          rom_read_and_D read[i] data
//  rsp_valid           out  1          response strobe, one cycle
//  rsp_id              out  ID_W       requester index of response
//  rsp_C / rsp_d_i / rsp_read_i  out 8/8/2  registered read data; 0 for an unused ROM
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0. rr_ptr=0. Tag pipeline cleared, so in-flight
//   reads are lost and no rsp_valid is issued for them after reset deasserts.
//  Arbitration (comb): search starts at rr_ptr and wraps modulo N_REQ; the first set req
//   wins. gnt=0 when flush=1 or no req is set. Accept in cycle T when gnt!=0.
//  rr_ptr update: on accept of r, rr_ptr <= (r==N_REQ-1) ? 0 : r+1; otherwise unchanged.
//  Cycle T+1: ce_rom_C=use_C[r], ce_rom_read_and_D=use_D[r]; an address is loaded only
//   when the matching ce is set, else that address is 0. Without an accept, both ce and
//   both addresses return to 0.
//  Tag pipeline: {valid, id, use_C, use_D}, depth ROM_LAT+1. At T+1+ROM_LAT the ROM data is
//   captured. rsp_valid=1 in cycle T+ROM_LAT+2 (T+3 for ROM_LAT=1). The captured field is
//   data/d_i/read_i when its use bit is set, otherwise 0. rsp_* holds its value while
//   rsp_valid=0.
//  A request with use_C=use_D=0 (STOP/MATCH/SNP) is still granted and answered with all
//   data 0; no ce is pulsed.
//  Requester rules: req and its fields stay stable until gnt. Dropping req before gnt is
//   allowed and is not an error. After gnt, the next request may be presented in the
//   following cycle, so back-to-back from one requester gives one grant per cycle when
//   alone.
//  flush: when flush=1, no grant that cycle, all tag valids cleared, ce outputs 0 next
//   cycle. A response that would be emitted in the flush cycle is suppressed. rr_ptr is
//   unchanged.
//  Simultaneous events: flush wins over req. Accept and response in the same cycle are
//   independent; there is no back-pressure on rsp.
//  Width: rsp_id = zero-extended requester index. Out-of-range ID_W is a parameter error
//   (generate-time $error).
// STRUCTURE
//  Shared config.v gets ROM_C_ADDR_A/C/G/T (2'b00..2'b11) and ROM_RD_LAT. Those names are
//   also used by get_data_1.
//  One sub-module, rr_arbiter_core (req, ptr -> one-hot gnt, index), is reusable by the
//   Occ ROM arbiter. The tag pipeline and ROM registers stay inline.
// TESTING  (ROM_LAT=1, N_REQ=2 unless noted)
//  1 Single read: req[0], use_D=1, addr_D=8'h15 at T -> gnt=01 at T; ce_rom_read_and_D=1,
//    addr=15 at T+1; rsp_valid, rsp_id=0, rsp_d_i=model D[15h], rsp_C=0 at T+3.
//  2 Contention: req=11 held 4 cycles, rr_ptr=0 -> gnt 01,10,01,10. Responses are ids
//    0,1,0,1 in consecutive cycles T+3..T+6.
//  3 C-only and null requests: use_C=1, addr_C=2'b10 -> rsp_C=C[G], rsp_d_i=0.
//    use_C=use_D=0 -> rsp_valid with all data 0, ce never asserted.
//  4 Flush: accept at T, flush at T+2 -> no rsp_valid at T+3. A req during flush gets
//    gnt=0, then is granted the next cycle.
//  5 Reset mid-flight: accept at T, rst_n=0 at T+1 for 1 cycle -> all outputs 0
//    immediately, no later rsp_valid, rr_ptr=0.
//  6 N_REQ=4, ROM_LAT=2: req=1111 continuous -> gnt 0,1,2,3,0 (pointer wraps). Each rsp is
//    4 cycles after its gnt, and ids stay in grant order.

Source files
------------

// File: rtl/rom_access_arbiter_pkg.sv
// rtl/rom_access_arbiter_pkg.sv - shared ROM encodings, read latency and sizing helper
package rom_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ROM_C_ADDR_A = 2'b00,
        ROM_C_ADDR_C = 2'b01,
        ROM_C_ADDR_G = 2'b10,
        ROM_C_ADDR_T = 2'b11
    } rom_c_base_e;

    localparam int ROM_RD_LAT = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_access_arbiter_core.sv
// rtl/rom_access_arbiter_core.sv - round-robin search from a pointer, one-hot grant plus index
module rr_arbiter_core
    import rom_access_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // One extra bit so ptr+k never overflows before the modulo fold.
    logic [IDX_W:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (en && !any && req[cand[IDX_W-1:0]]) begin
                any                    = 1'b1;
                idx                    = cand[IDX_W-1:0];
                gnt[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - round-robin sharing of rom_C / rom_read_and_D with tagged responses
module rom_access_arbiter
    import rom_access_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ID_W    = 3,
    parameter int ROM_LAT = ROM_RD_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_use_C,
    input  logic [N_REQ-1:0]     req_use_D,
    input  logic [2*N_REQ-1:0]   req_addr_C,
    input  logic [8*N_REQ-1:0]   req_addr_D,
    output logic [N_REQ-1:0]     gnt,
    output logic                 ce_rom_C,
    output logic                 ce_rom_read_and_D,
    output logic [1:0]           addr_rom_C,
    output logic [7:0]           addr_rom_read_and_D,
    input  logic [7:0]           data,
    input  logic [7:0]           d_i,
    input  logic [1:0]           read_i,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_C,
    output logic [7:0]           rsp_d_i,
    output logic [1:0]           rsp_read_i
);

    localparam int PTR_W = idx_width(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ || ROM_LAT < 1) begin : g_param_err
        $error("rom_access_arbiter: N_REQ must be 2..8, 2**ID_W >= N_REQ, ROM_LAT >= 1");
    end

    logic [N_REQ-1:0]            gnt_core;
    logic [PTR_W-1:0]            gnt_idx;
    logic                        gnt_any;
    logic                        accept;

    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                        ce_c_q, ce_c_d, ce_d_q, ce_d_d;
    logic [1:0]                  addr_c_q, addr_c_d;
    logic [7:0]                  addr_d_q, addr_d_d;

    logic [ROM_LAT:0]            tag_valid_q, tag_valid_d;
    logic [ROM_LAT:0]            tag_use_c_q, tag_use_c_d;
    logic [ROM_LAT:0]            tag_use_d_q, tag_use_d_d;
    logic [ROM_LAT:0][ID_W-1:0]  tag_id_q, tag_id_d;

    logic                        rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]             rsp_id_q, rsp_id_d;
    logic [7:0]                  rsp_c_q, rsp_c_d;
    logic [7:0]                  rsp_d_q, rsp_d_d;
    logic [1:0]                  rsp_r_q, rsp_r_d;

    rr_arbiter_core #(.N(N_REQ), .IDX_W(PTR_W)) u_core (
        .en  (~flush),
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (gnt_core),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Grant is combinational, so it is masked while reset is held to keep all outputs at 0.
    assign gnt    = gnt_core & {N_REQ{rst_n}};
    assign accept = gnt_any & rst_n;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        ce_c_d   = accept && req_use_C[gnt_idx];
        ce_d_d   = accept && req_use_D[gnt_idx];
        addr_c_d = ce_c_d ? req_addr_C[{gnt_idx, 1'b0} +: 2] : 2'b00;
        addr_d_d = ce_d_d ? req_addr_D[{gnt_idx, 3'b000} +: 8] : 8'h00;

        tag_valid_d = {tag_valid_q[ROM_LAT-1:0], accept};
        tag_use_c_d = {tag_use_c_q[ROM_LAT-1:0], ce_c_d};
        tag_use_d_d = {tag_use_d_q[ROM_LAT-1:0], ce_d_d};
        tag_id_d    = {tag_id_q[ROM_LAT-1:0], ID_W'(gnt_idx)};
        if (flush) begin
            tag_valid_d = '0;
        end

        // The oldest tag lines up with ROM data valid this cycle.
        rsp_valid_d = tag_valid_q[ROM_LAT] & ~flush;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rsp_d_d     = rsp_d_q;
        rsp_r_d     = rsp_r_q;
        if (rsp_valid_d) begin
            rsp_id_d = tag_id_q[ROM_LAT];
            rsp_c_d  = tag_use_c_q[ROM_LAT] ? data   : 8'h00;
            rsp_d_d  = tag_use_d_q[ROM_LAT] ? d_i    : 8'h00;
            rsp_r_d  = tag_use_d_q[ROM_LAT] ? read_i : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            ce_c_q      <= 1'b0;
            ce_d_q      <= 1'b0;
            addr_c_q    <= '0;
            addr_d_q    <= '0;
            tag_valid_q <= '0;
            tag_use_c_q <= '0;
            tag_use_d_q <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_c_q     <= '0;
            rsp_d_q     <= '0;
            rsp_r_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            ce_c_q      <= ce_c_d;
            ce_d_q      <= ce_d_d;
            addr_c_q    <= addr_c_d;
            addr_d_q    <= addr_d_d;
            tag_valid_q <= tag_valid_d;
            tag_use_c_q <= tag_use_c_d;
            tag_use_d_q <= tag_use_d_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_d_q     <= rsp_d_d;
            rsp_r_q     <= rsp_r_d;
        end
    end

    assign ce_rom_C            = ce_c_q;
    assign ce_rom_read_and_D   = ce_d_q;
    assign addr_rom_C          = addr_c_q;
    assign addr_rom_read_and_D = addr_d_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_id              = rsp_id_q;
    assign rsp_C               = rsp_c_q;
    assign rsp_d_i             = rsp_d_q;
    assign rsp_read_i          = rsp_r_q;

endmodule
